ahb_sram_slave: RTL

- Parametrised AHB-Lite slave: byte-addressable on-chip SRAM behind the ahb_intf signal set.
- Next-generation slave with:
  - configurable data width, depth, base address and wait states;
  - byte/halfword/word (up to DATA_W) write strobing;
  - two-cycle ERROR response for illegal accesses.
- Sits behind the decoder; driven by HSELx and the global master signals; returns HREADYOUT/HRESP/HRDATA to the mux.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_sram_byte_ram.sv | 32 +++
 rtl/ahb_sram_slave.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg: AHB-Lite transfer encodings and SRAM slave state type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slave_state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_sram_byte_ram.sv
// ----------------------------------------------------------------------------
// ahb_sram_byte_ram: word array with per-byte write enables, async read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_sram_byte_ram #(
  parameter int  DATA_W    = 32,
  parameter int  MEM_DEPTH = 1024,
  localparam int BYTES     = DATA_W / 8,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic [BYTES-1:0]  we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave: AHB-Lite SRAM slave with wait states and two-cycle ERROR
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              MEM_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HSELx,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int              BYTES     = DATA_W / 8;
  localparam int              LANE_W    = $clog2(BYTES);
  localparam int              IDX_W     = $clog2(MEM_DEPTH);
  localparam int              OFF_W     = LANE_W + IDX_W;
  localparam logic [ADDR_W:0] REGION    = (ADDR_W+1)'(MEM_DEPTH * BYTES);
  localparam logic [3:0]      LAST_WAIT = 4'(WAIT_STATES - 1);

  slave_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OFF_W-1:0]  addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

  logic [ADDR_W-1:0] offset;
  logic [LANE_W-1:0] align_mask;
  logic              addr_err;
  logic              accept;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] rdata;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  assign offset     = HADDR - BASE_ADDR;
  assign align_mask = LANE_W'((1 << HSIZE) - 1);
  assign addr_err   = (HSIZE > 3'(LANE_W))
                    || (|(HADDR[LANE_W-1:0] & align_mask))
                    || ({1'b0, offset} >= REGION);
  assign accept     = HSELx && HREADY
                    && (htrans_t'(HTRANS) == HTRANS_NONSEQ || htrans_t'(HTRANS) == HTRANS_SEQ);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYOUT high: next address phase is sampled here.
        if (state_q == S_DATA && !write_q) hrdata_d = rdata;
        if (accept) begin
          addr_d  = offset[OFF_W-1:0];
          write_d = HWRITE;
          size_d  = HSIZE;
          if (addr_err)             state_d = S_ERR1;
          else if (WAIT_STATES > 0) state_d = S_WAIT;
          else                      state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hrdata_q <= hrdata_d;
    end
  end

  // A lane is written when it falls in the same size-aligned block as the latched address.
  always_comb begin
    be = '0;
    for (int b = 0; b < BYTES; b++) begin
      be[b] = (state_q == S_DATA) && write_q
              && ((b >> size_q) == (int'(addr_q[LANE_W-1:0]) >> size_q));
    end
  end

  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (state_q == S_DATA && !write_q) ? rdata : hrdata_q;

  ahb_sram_byte_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (be),
    .idx_i   (addr_q[OFF_W-1:LANE_W]),
    .wdata_i (HWDATA),
    .rdata_o (rdata)
  );

endmodule

`default_nettype wire
